// File: rtl/gcd_rr_arbiter_pkg.sv
// Shared constants for the round-robin GCD arbiter: FSM state encoding,
// state width, default data width and the picker index-width helper.
package gcd_rr_arbiter_pkg;

  localparam int ST_W = 2;

  localparam logic [ST_W-1:0] ST_IDLE  = 2'd0;
  localparam logic [ST_W-1:0] ST_ISSUE = 2'd1;
  localparam logic [ST_W-1:0] ST_WAIT  = 2'd2;
  localparam logic [ST_W-1:0] ST_RESP  = 2'd3;

  localparam int DEF_W = 8;

  function automatic int rr_idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/gcd_rr_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request searching upward
// from i_ptr+1 with wrap-around.
module gcd_rr_arbiter_rr_pick
  import gcd_rr_arbiter_pkg::*;
#(
  parameter int N  = 4,
  parameter int IW = rr_idx_w(N)
) (
  input  logic [N-1:0]  i_req,
  input  logic [IW-1:0] i_ptr,
  output logic          o_valid,
  output logic [IW-1:0] o_idx
);

  logic [IW:0] w_sum;

  // Scan farthest-first so the candidate nearest ptr+1 overwrites the rest.
  always_comb begin
    o_valid = 1'b0;
    o_idx   = {IW{1'b0}};
    w_sum   = {(IW+1){1'b0}};
    for (int off = N; off >= 1; off--) begin
      w_sum   = {1'b0, i_ptr} + (IW+1)'(off);
      w_sum   = (w_sum >= (IW+1)'(N)) ? (w_sum - (IW+1)'(N)) : w_sum;
      o_valid = i_req[w_sum[IW-1:0]] ? 1'b1 : o_valid;
      o_idx   = i_req[w_sum[IW-1:0]] ? w_sum[IW-1:0] : o_idx;
    end
  end

endmodule

// File: rtl/gcd_rr_arbiter.sv
// Shares one GCD engine among N requesters with round-robin grant; zero operand
// pairs are answered locally. Define GCD_ARB_TIMEOUT_EN for the WAIT timeout.
module gcd_rr_arbiter
  import gcd_rr_arbiter_pkg::*;
#(
  parameter int N       = 4,
  parameter int W       = DEF_W,
  parameter int TIMEOUT = 64
) (
  input  logic           clk,
  input  logic           clr,
  input  logic [N-1:0]   req,
  input  logic [N*W-1:0] a_in,
  input  logic [N*W-1:0] b_in,
  output logic [N-1:0]   gnt,
  output logic [N-1:0]   rsp_valid,
  output logic [W-1:0]   rsp_data,
`ifdef GCD_ARB_TIMEOUT_EN
  output logic           rsp_err,
`endif
  output logic           eng_go,
  output logic [W-1:0]   eng_a,
  output logic [W-1:0]   eng_b,
  input  logic           eng_done,
  input  logic [W-1:0]   eng_result
);

  localparam int IW = rr_idx_w(N);

`ifdef GCD_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);
  logic [CW-1:0] r_cnt;
  logic          r_rsp_err;
`endif

  logic [ST_W-1:0] r_state;
  logic [IW-1:0]   r_ptr;
  logic [IW-1:0]   r_k;
  logic [N-1:0]    r_gnt;
  logic [N-1:0]    r_rsp_valid;
  logic [W-1:0]    r_rsp_data;
  logic            r_eng_go;
  logic [W-1:0]    r_eng_a;
  logic [W-1:0]    r_eng_b;

  logic            w_pick_valid;
  logic [IW-1:0]   w_pick_idx;
  logic [W-1:0]    w_a_sel;
  logic [W-1:0]    w_b_sel;
  logic [N-1:0]    w_pick_oh;
  logic [N-1:0]    w_k_oh;
  logic            w_bypass;

  if (N < 2 || N > 8 || TIMEOUT < 1) begin : g_param_check
    $error("gcd_rr_arbiter: unsupported parameter set");
  end

  gcd_rr_arbiter_rr_pick #(.N(N), .IW(IW)) u_pick (
    .i_req   (req),
    .i_ptr   (r_ptr),
    .o_valid (w_pick_valid),
    .o_idx   (w_pick_idx)
  );

  assign w_a_sel   = a_in[int'(w_pick_idx) * W +: W];
  assign w_b_sel   = b_in[int'(w_pick_idx) * W +: W];
  assign w_pick_oh = {{(N-1){1'b0}}, 1'b1} << w_pick_idx;
  assign w_k_oh    = {{(N-1){1'b0}}, 1'b1} << r_k;
  assign w_bypass  = (w_a_sel == {W{1'b0}}) || (w_b_sel == {W{1'b0}});

  // Grant is launched at capture so it lands in ISSUE (engine path) or RESP (bypass).
  always_ff @(posedge clk) begin
    if (clr) begin
      r_state     <= ST_IDLE;
      r_ptr       <= IW'(N - 1);
      r_k         <= {IW{1'b0}};
      r_gnt       <= {N{1'b0}};
      r_rsp_valid <= {N{1'b0}};
      r_rsp_data  <= {W{1'b0}};
      r_eng_go    <= 1'b0;
      r_eng_a     <= {W{1'b0}};
      r_eng_b     <= {W{1'b0}};
`ifdef GCD_ARB_TIMEOUT_EN
      r_cnt       <= {CW{1'b0}};
      r_rsp_err   <= 1'b0;
`endif
    end else begin
      r_gnt       <= {N{1'b0}};
      r_rsp_valid <= {N{1'b0}};
      r_eng_go    <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_pick_valid) begin
            r_k     <= w_pick_idx;
            r_eng_a <= w_a_sel;
            r_eng_b <= w_b_sel;
            r_gnt   <= w_pick_oh;
            if (w_bypass) begin
              r_rsp_data  <= w_a_sel | w_b_sel;
              r_rsp_valid <= w_pick_oh;
`ifdef GCD_ARB_TIMEOUT_EN
              r_rsp_err   <= 1'b0;
`endif
              r_state     <= ST_RESP;
            end else begin
              r_eng_go <= 1'b1;
              r_state  <= ST_ISSUE;
            end
          end
        end
        ST_ISSUE: begin
`ifdef GCD_ARB_TIMEOUT_EN
          r_cnt   <= {CW{1'b0}};
`endif
          r_state <= ST_WAIT;
        end
        ST_WAIT: begin
          if (eng_done) begin
            r_rsp_data  <= eng_result;
            r_rsp_valid <= w_k_oh;
`ifdef GCD_ARB_TIMEOUT_EN
            r_rsp_err   <= 1'b0;
`endif
            r_state     <= ST_RESP;
`ifdef GCD_ARB_TIMEOUT_EN
          end else if (r_cnt == CW'(TIMEOUT - 1)) begin
            r_rsp_data  <= {W{1'b0}};
            r_rsp_valid <= w_k_oh;
            r_rsp_err   <= 1'b1;
            r_state     <= ST_RESP;
          end else begin
            r_cnt <= r_cnt + CW'(1);
`endif
          end
        end
        ST_RESP: begin
          r_ptr   <= r_k;
          r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign gnt       = r_gnt;
  assign rsp_valid = r_rsp_valid;
  assign rsp_data  = r_rsp_data;
  assign eng_go    = r_eng_go;
  assign eng_a     = r_eng_a;
  assign eng_b     = r_eng_b;
`ifdef GCD_ARB_TIMEOUT_EN
  assign rsp_err   = r_rsp_err;
`endif

endmodule
